// File: rtl/symbol_weight_acc_pkg.sv
// Shared constants and state encoding for the symbol-weight accumulator.
package symbol_weight_acc_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 6;
    localparam int DEF_ACC_WIDTH  = 16;
    localparam int DEF_CNT_WIDTH  = 8;
    localparam int NUM_SYM        = 2 ** DEF_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

endpackage

// File: rtl/symbol_weight_acc_sat_add.sv
// Unsigned adder that clamps to all-ones on carry-out and flags the clamp.
module symbol_weight_acc_sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sat  = full[W];
    assign sum  = full[W] ? '1 : full[W-1:0];

endmodule

// File: rtl/symbol_weight_acc.sv
// Captures the LUT weights for a frame, then sums the weight of each streamed symbol.
//   state | meaning
//   IDLE  | wait for start; outputs of the last frame held
//   LOAD  | lut_addr stable, register all ROM weights
//   RUN   | accept symbols, accumulate weight and count
//   OUT   | present result until acc_ready
module symbol_weight_acc
    import symbol_weight_acc_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] n_in,
    output logic [ADDR_WIDTH-1:0] lut_addr,
    input  logic [DATA_WIDTH-1:0] q_0,
    input  logic [DATA_WIDTH-1:0] q_1,
    input  logic [DATA_WIDTH-1:0] q_2,
    input  logic [DATA_WIDTH-1:0] q_3,
    input  logic [DATA_WIDTH-1:0] q_4,
    input  logic [DATA_WIDTH-1:0] q_5,
    input  logic [DATA_WIDTH-1:0] q_6,
    input  logic [DATA_WIDTH-1:0] q_7,
    input  logic [DATA_WIDTH-1:0] q_8,
    input  logic [DATA_WIDTH-1:0] q_9,
    input  logic [DATA_WIDTH-1:0] q_10,
    input  logic [DATA_WIDTH-1:0] q_11,
    input  logic [DATA_WIDTH-1:0] q_12,
    input  logic [DATA_WIDTH-1:0] q_13,
    input  logic [DATA_WIDTH-1:0] q_14,
    input  logic [DATA_WIDTH-1:0] q_15,
    input  logic                  sym_valid,
    output logic                  sym_ready,
    input  logic [ADDR_WIDTH-1:0] sym,
    input  logic                  sym_last,
    output logic                  acc_valid,
    input  logic                  acc_ready,
    output logic [ACC_WIDTH-1:0]  acc_data,
    output logic [CNT_WIDTH-1:0]  sym_count,
    output logic                  overflow,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]  res_acc_q, res_acc_d;
    logic [CNT_WIDTH-1:0]  res_cnt_q, res_cnt_d;
    logic [DATA_WIDTH-1:0] w_q [NUM_SYM];
    logic [DATA_WIDTH-1:0] w_d [NUM_SYM];
    logic [DATA_WIDTH-1:0] q_vec [NUM_SYM];

    logic [ACC_WIDTH-1:0]  w_ext;
    logic [ACC_WIDTH-1:0]  acc_sum;
    logic                  acc_sat;
    logic [CNT_WIDTH-1:0]  cnt_sum;
    logic                  cnt_sat_unused;

    assign q_vec = '{q_0, q_1, q_2, q_3, q_4, q_5, q_6, q_7,
                     q_8, q_9, q_10, q_11, q_12, q_13, q_14, q_15};

    assign w_ext = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, w_q[sym]};

    symbol_weight_acc_sat_add #(.W(ACC_WIDTH)) u_acc_add (
        .a   (acc_q),
        .b   (w_ext),
        .sum (acc_sum),
        .sat (acc_sat)
    );

    // The counter clamps silently; its saturation flag has no consumer.
    symbol_weight_acc_sat_add #(.W(CNT_WIDTH)) u_cnt_add (
        .a   (cnt_q),
        .b   (CNT_WIDTH'(1)),
        .sum (cnt_sum),
        .sat (cnt_sat_unused)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_acc_d = res_acc_q;
        res_cnt_d = res_cnt_q;
        w_d       = w_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = n_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_d     = q_vec;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (sym_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_sum;
                    if (acc_sat) begin
                        ovf_d = 1'b1;
                    end
                    if (sym_last) begin
                        res_acc_d = acc_sum;
                        res_cnt_d = cnt_sum;
                        state_d   = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (acc_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_acc_q <= '0;
            res_cnt_q <= '0;
            for (int k = 0; k < NUM_SYM; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_acc_q <= res_acc_d;
            res_cnt_q <= res_cnt_d;
            w_q       <= w_d;
        end
    end

    assign lut_addr  = addr_q;
    assign sym_ready = (state_q == ST_RUN);
    assign acc_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign acc_data  = res_acc_q;
    assign sym_count = res_cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_symbol_weight_acc.sv
// Bench for symbol_weight_acc with a behavioural LUT ROM (w_k = 4*(N-k) for k < N, else 0).
module tb_symbol_weight_acc;

    localparam int AW = 4;
    localparam int DW = 6;
    localparam int ACW = 8;
    localparam int CW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [AW-1:0]  n_in;
    logic [AW-1:0]  lut_addr;
    logic [DW-1:0]  qv [16];
    logic           sym_valid;
    logic           sym_ready;
    logic [AW-1:0]  sym;
    logic           sym_last;
    logic           acc_valid;
    logic           acc_ready;
    logic [ACW-1:0] acc_data;
    logic [CW-1:0]  sym_count;
    logic           overflow;
    logic           busy;

    int total = 0;
    int bad = 0;

    typedef struct {
        int acc;
        int cnt;
        int ovf;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0]      n;
        int              len;
        logic [4:0][3:0] s;
        bit              rnd_gap;
        int              acc;
        int              cnt;
        int              ovf;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            if (k < int'(lut_addr)) qv[k] = DW'(4 * (int'(lut_addr) - k));
            else                    qv[k] = '0;
        end
    end

    symbol_weight_acc #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(ACW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .lut_addr(lut_addr),
        .q_0(qv[0]), .q_1(qv[1]), .q_2(qv[2]), .q_3(qv[3]),
        .q_4(qv[4]), .q_5(qv[5]), .q_6(qv[6]), .q_7(qv[7]),
        .q_8(qv[8]), .q_9(qv[9]), .q_10(qv[10]), .q_11(qv[11]),
        .q_12(qv[12]), .q_13(qv[13]), .q_14(qv[14]), .q_15(qv[15]),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym(sym), .sym_last(sym_last),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .sym_count(sym_count), .overflow(overflow), .busy(busy)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int a, input int c, input int o);
        exp_t e;
        e.acc = a;
        e.cnt = c;
        e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic start_frame(input logic [3:0] n);
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = n;
        @(posedge clk); #1;
        start = 1'b0;
        chk("lut_addr_latched", int'(lut_addr), int'(n));
        chk("ready_low_in_load", int'(sym_ready), 0);
        chk("busy_in_load", int'(busy), 1);
        @(posedge clk); #1;
        chk("ready_latency", int'(sym_ready), 1);
    endtask

    task automatic send_sym(input logic [3:0] s, input bit last, input int gap);
        repeat (gap) begin
            sym_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk("ready_before_hs", int'(sym_ready), 1);
        sym_valid = 1'b1;
        sym       = s;
        sym_last  = last;
        @(posedge clk); #1;
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic collect(input int hold, input bit start_hs);
        exp_t e;
        int waited = 0;
        while (!acc_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!acc_valid) begin
            total++;
            bad++;
            $display("FAIL acc_valid_timeout actual=0 required=1");
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty actual=result required=none");
            return;
        end
        e = sb.pop_front();
        repeat (hold) begin
            chk("hold_valid", int'(acc_valid), 1);
            chk("hold_acc", int'(acc_data), e.acc);
            chk("hold_cnt", int'(sym_count), e.cnt);
            @(posedge clk); #1;
        end
        chk("acc_data", int'(acc_data), e.acc);
        chk("sym_count", int'(sym_count), e.cnt);
        chk("overflow", int'(overflow), e.ovf);
        acc_ready = 1'b1;
        start     = start_hs;
        @(posedge clk); #1;
        acc_ready = 1'b0;
        start     = 1'b0;
        chk("valid_drop", int'(acc_valid), 0);
        chk("idle_after_hs", int'(busy), 0);
        if (start_hs) begin
            @(posedge clk); #1;
            chk("start_in_out_ignored", int'(busy), 0);
        end
    endtask

    task automatic set_vec(input int i, input logic [3:0] n, input int len,
                           input logic [4:0][3:0] s, input bit g,
                           input int a, input int c, input int o);
        tbl[i].n = n; tbl[i].len = len; tbl[i].s = s; tbl[i].rnd_gap = g;
        tbl[i].acc = a; tbl[i].cnt = c; tbl[i].ovf = o;
    endtask

    initial begin
        // s packs symbols with element 0 in the low nibble.
        set_vec(0, 4'd4,  4, {4'd0, 4'd3, 4'd2, 4'd1, 4'd0},   1'b0, 40,  4, 0);
        set_vec(1, 4'd4,  3, {4'd0, 4'd0, 4'd0, 4'd15, 4'd5},  1'b0, 16,  3, 0);
        set_vec(2, 4'd15, 5, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0},   1'b0, 255, 5, 1);
        set_vec(3, 4'd1,  1, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0},   1'b0, 4,   1, 0);
        set_vec(4, 4'd8,  3, {4'd0, 4'd0, 4'd7, 4'd7, 4'd7},   1'b1, 12,  3, 0);

        rst_n = 1'b0; start = 1'b0; n_in = '0; sym_valid = 1'b0;
        sym = '0; sym_last = 1'b0; acc_ready = 1'b0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(acc_valid), 0);
        chk("rst_ready", int'(sym_ready), 0);
        chk("rst_acc", int'(acc_data), 0);
        chk("rst_cnt", int'(sym_count), 0);
        chk("rst_lut_addr", int'(lut_addr), 0);
        rst_n = 1'b1;

        // idle must not take a symbol even when start and sym_valid coincide
        @(posedge clk); #1;
        sym_valid = 1'b1;
        chk("idle_ready_low", int'(sym_ready), 0);

        for (int i = 0; i < 5; i++) begin
            push_exp(tbl[i].acc, tbl[i].cnt, tbl[i].ovf);
            start_frame(tbl[i].n);
            for (int j = 0; j < tbl[i].len; j++) begin
                send_sym(tbl[i].s[j], (j == tbl[i].len - 1),
                         tbl[i].rnd_gap ? int'($urandom_range(0, 2)) : 0);
            end
            chk("valid_latency", int'(acc_valid), 1);
            collect(0, 1'b0);
            chk("lut_addr_hold", int'(lut_addr), int'(tbl[i].n));
        end

        // start during RUN and OUT, with result backpressure
        push_exp(28, 2, 0);
        start_frame(4'd4);
        send_sym(4'd0, 1'b0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_sym(4'd1, 1'b1, 0);
        chk("valid_latency_bp", int'(acc_valid), 1);
        start = 1'b1;
        collect(3, 1'b1);

        // symbol counter clamps at 255 with no flag
        push_exp(0, 255, 0);
        start_frame(4'd0);
        sym_valid = 1'b1; sym = 4'd0; sym_last = 1'b0;
        repeat (259) begin
            @(posedge clk); #1;
        end
        send_sym(4'd0, 1'b1, 0);
        collect(0, 1'b0);

        // asynchronous reset in the middle of RUN, previous result is non-zero
        push_exp(28, 2, 0);
        start_frame(4'd4);
        send_sym(4'd0, 1'b0, 0);
        send_sym(4'd1, 1'b1, 0);
        collect(0, 1'b0);
        start_frame(4'd5);
        send_sym(4'd0, 1'b0, 0);
        send_sym(4'd1, 1'b0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(sym_ready), 0);
        chk("mid_rst_valid", int'(acc_valid), 0);
        chk("mid_rst_acc", int'(acc_data), 0);
        chk("mid_rst_cnt", int'(sym_count), 0);
        chk("mid_rst_lut_addr", int'(lut_addr), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        #3;
        rst_n = 1'b1;

        push_exp(12, 2, 0);
        start_frame(4'd2);
        send_sym(4'd0, 1'b0, 0);
        send_sym(4'd1, 1'b1, 0);
        collect(0, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
